// File: rtl/slice_scan_engine.sv
`default_nettype none
// ============================================================================
// Module      : slice_scan_engine
// Description : Buffers DEPTH slices of N bits, then replays them from a
//               programmable index, scanning up or down with modulo-DEPTH wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_scan_engine #(
  parameter int N     = 25,
  parameter int DEPTH = 64,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [AW-1:0] start_idx,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int            c_IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_dir;
  logic [c_IW-1:0] r_start_idx;
  logic [c_IW-1:0] r_wr_cnt;
  logic [c_IW-1:0] r_rd_cnt;
  logic [c_IW-1:0] r_rd_idx;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_mem [DEPTH];

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_idx_ok;
  logic [c_IW-1:0] w_rd_idx_nxt;
  logic [c_IW-1:0] w_rd_cnt_nxt;

  // clear wins over any handshake presented in the same cycle
  assign w_in_fire    = r_in_ready & in_valid & ~clear;
  assign w_out_fire   = r_out_valid & out_ready & ~clear;
  assign w_idx_ok     = ({1'b0, start_idx} < (AW+1)'(DEPTH));
  assign w_rd_cnt_nxt = r_rd_cnt + c_IW'(1);

  always_comb begin
    w_rd_idx_nxt = r_rd_idx;
    if (r_dir) w_rd_idx_nxt = (r_rd_idx == c_LAST) ? '0 : r_rd_idx + c_IW'(1);
    else       w_rd_idx_nxt = (r_rd_idx == '0) ? c_LAST : r_rd_idx - c_IW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_mem[r_wr_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_start_idx <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_idx    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state     <= S_IDLE;
        r_wr_cnt    <= '0;
        r_rd_cnt    <= '0;
        r_rd_idx    <= '0;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state     <= S_FILL;
              r_dir       <= dir;
              r_start_idx <= w_idx_ok ? start_idx[c_IW-1:0] : '0;
              r_wr_cnt    <= '0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          S_FILL: begin
            if (w_in_fire) begin
              r_wr_cnt <= r_wr_cnt + c_IW'(1);
              if (r_wr_cnt == c_LAST) begin
                r_state     <= S_DRAIN;
                r_wr_cnt    <= '0;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b0;
                r_rd_idx    <= r_start_idx;
                r_rd_cnt    <= '0;
              end
            end
          end
          S_DRAIN: begin
            if (w_out_fire) begin
              if (r_rd_cnt == c_LAST) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_rd_cnt    <= '0;
                r_rd_idx    <= '0;
              end else begin
                r_rd_cnt   <= w_rd_cnt_nxt;
                r_rd_idx   <= w_rd_idx_nxt;
                r_out_last <= (w_rd_cnt_nxt == c_LAST);
              end
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_data  = r_out_valid ? r_mem[r_rd_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_slice_scan_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_slice_scan_engine
// Description : Randomised self-checking bench for slice_scan_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slice_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, dir, clear, in_valid, out_ready, sel;
  logic [7:0]  start_idx;
  logic [24:0] in_data;

  logic        a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic [24:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic [24:0] b_out_data;

  logic        in_ready, out_valid, out_last, busy, done;
  logic [24:0] out_data;

  int total = 0;
  int bad   = 0;

  slice_scan_engine u_dut64 (
    .clk(clk), .rst(rst), .start(start & ~sel), .dir(dir), .start_idx(start_idx),
    .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy), .done(a_done)
  );

  slice_scan_engine #(.N(25), .DEPTH(25), .AW(8)) u_dut25 (
    .clk(clk), .rst(rst), .start(start & sel), .dir(dir), .start_idx(start_idx),
    .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign out_last  = sel ? b_out_last  : a_out_last;
  assign busy      = sel ? b_busy      : a_busy;
  assign done      = sel ? b_done      : a_done;
  assign out_data  = sel ? b_out_data  : a_out_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_in_ready"},  32'(in_ready),  0);
    check_val({tag, "_out_valid"}, 32'(out_valid), 0);
    check_val({tag, "_out_last"},  32'(out_last),  0);
    check_val({tag, "_busy"},      32'(busy),      0);
    check_val({tag, "_out_data"},  32'(out_data),  0);
  endtask

  // Called at a negedge; returns at a negedge. abort_at / rst_at < 0 disable the abort.
  task automatic run_frame(input bit d, input int sidx, input bit bp, input bit rnd,
                           input int abort_at, input int rst_at, input bit spur,
                           input bit chain);
    int D, idx0, wr, rd, cyc;
    logic [24:0] slot[$];
    logic [24:0] exp_v;
    D    = sel ? 25 : 64;
    idx0 = (sidx >= D) ? 0 : sidx;
    slot = {};
    start = 1'b1; dir = d; start_idx = 8'(sidx);
    @(negedge clk);
    start = 1'b0; dir = ~d; start_idx = 8'($urandom);
    check_val("busy_fill", 32'(busy), 1);
    wr = 0; cyc = 0;
    while (wr < D) begin
      check_val("in_ready_fill", 32'(in_ready), 1);
      check_val("out_valid_fill", 32'(out_valid), 0);
      if (rst_at == wr) begin
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_idle_outputs("async_rst");
        check_val("async_rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      start = (spur && wr == 3);
      if (bp && (cyc % 3 == 2)) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = rnd ? 25'($urandom) : 25'(wr);
        slot.push_back(in_data);
        wr++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    check_val("first_out_valid", 32'(out_valid), 1);
    check_val("in_ready_drain", 32'(in_ready), 0);
    rd = 0; cyc = 0;
    while (rd < D) begin
      exp_v = slot[(d ? (idx0 + rd) : (idx0 - rd + D)) % D];
      check_val("out_valid", 32'(out_valid), 1);
      check_val("out_data", 32'(out_data), 32'(exp_v));
      check_val("out_last", 32'(out_last), 32'(rd == D - 1));
      check_val("done_drain", 32'(done), 0);
      if (rd == abort_at) begin
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b0;
        check_idle_outputs("clear");
        check_val("clear_done", 32'(done), 0);
        @(negedge clk);
        check_val("clear_done_next", 32'(done), 0);
        return;
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) rd++;
      cyc++;
      if (cyc > 2000) begin
        check_val("drain_timeout", 32'(rd), 32'(D));
        out_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_val("done_pulse", 32'(done), 1);
    check_idle_outputs("after_last");
    if (!chain) begin
      @(negedge clk);
      check_val("done_cleared", 32'(done), 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; dir = 1'b0; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; sel = 1'b0; start_idx = '0; in_data = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_val("reset_done", 32'(done), 0);
    rst = 1'b1;
    @(negedge clk);

    run_frame(1'b1, 0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    run_frame(1'b0, 5, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
    sel = 1'b1;
    run_frame(1'b1, 20, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    run_frame(1'b1, 30, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    run_frame(1'b0, 3, 1'b1, 1'b1, -1, -1, 1'b0, 1'b0);
    sel = 1'b0;
    for (int i = 0; i < 3; i++)
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 70)), 1'b1, 1'b1,
                -1, -1, 1'b0, 1'b0);
    run_frame(1'b1, 7, 1'b0, 1'b1, 10, -1, 1'b0, 1'b0);
    run_frame(1'b0, 9, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
    run_frame(1'b1, 0, 1'b0, 1'b1, -1, 12, 1'b0, 1'b0);
    run_frame(1'b1, 2, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
    run_frame(1'b1, 0, 1'b1, 1'b1, -1, -1, 1'b1, 1'b1);
    run_frame(1'b0, 63, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
